id_decode_stage: RTL and testbench

//  Instruction-decode stage of the LC-3b pipeline; drives the ID/EXE pipeline register.
//  - Holds the 8x16 register file and reads the source operands.
//  - Generates the sign/zero-extended immediate and builds the instruction packet.
//  - Detects load-use hazards against the instruction in EXE and holds the front end.

---
 rtl/lc3b_types.sv | 66 ++++++
 rtl/id_regfile.sv | 41 ++++
 rtl/id_decode_stage.sv | 186 ++++++++++++++++++
 tb/tb_id_decode_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: register index, opcode enum, instruction packet and
// the immediate-extension helper used by the decode stage.
package lc3b_types;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LDB  = 4'b0010,
        OP_STB  = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_SHF  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        SEXT_NONE  = 3'd0,
        SEXT_IMM5  = 3'd1,
        SEXT_OFF6  = 3'd2,
        SEXT_OFF9  = 3'd3,
        SEXT_OFF11 = 3'd4,
        ZEXT_IMM4  = 3'd5,
        ZEXT_TRAP8 = 3'd6
    } lc3b_sext_sel;

    localparam lc3b_reg R7_IDX = 3'd7;

    typedef struct packed {
        logic       valid;
        lc3b_opcode opcode;
        lc3b_reg    dest;
        lc3b_reg    sr1;
        lc3b_reg    sr2;
        lc3b_word   pc;
        logic       imm_mode;
        logic       load_en;
        logic       store_en;
        logic       regfile_we;
    } lc3b_ipacket;

    function automatic lc3b_word extend_imm(input lc3b_sext_sel sel, input lc3b_word instr);
        lc3b_word result;
        case (sel)
            SEXT_IMM5:  result = {{11{instr[4]}},  instr[4:0]};
            SEXT_OFF6:  result = {{10{instr[5]}},  instr[5:0]};
            SEXT_OFF9:  result = {{7{instr[8]}},   instr[8:0]};
            SEXT_OFF11: result = {{5{instr[10]}},  instr[10:0]};
            ZEXT_IMM4:  result = {12'h000,         instr[3:0]};
            ZEXT_TRAP8: result = {8'h00,           instr[7:0]};
            default:    result = 16'h0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 8x16 register file: two combinational read ports with write-through
// bypass and one synchronous write port.
module id_regfile
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic     clk,
    input  logic     reset_n,
    input  lc3b_reg  rd_idx_a,
    input  lc3b_reg  rd_idx_b,
    output lc3b_word rd_data_a,
    output lc3b_word rd_data_b,
    input  logic     we,
    input  lc3b_reg  wr_idx,
    input  lc3b_word wr_data
);

    lc3b_word   regs_reg [8];
    logic [7:0] wr_sel;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
            assign wr_sel[gi] = we && (wr_idx == lc3b_reg'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!reset_n)
                regs_reg[i] <= RESET_VALUE;
            else if (wr_sel[i])
                regs_reg[i] <= wr_data;
        end
    end

    // A read of the register being written this cycle sees the new value.
    assign rd_data_a = wr_sel[rd_idx_a] ? wr_data : regs_reg[rd_idx_a];
    assign rd_data_b = wr_sel[rd_idx_b] ? wr_data : regs_reg[rd_idx_b];

endmodule

// File: rtl/id_decode_stage.sv
// LC-3b instruction-decode stage: operand read, immediate extension, packet
// build and load-use hazard hold with a programmable number of bubbles.
module id_decode_stage
    import lc3b_types::*;
#(
    parameter int          LOAD_USE_STALLS = 1,
    parameter logic [15:0] REG_RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic        mem_stall,
    input  lc3b_ipacket exe_ipacket,
    input  logic        wb_en,
    input  lc3b_reg     wb_dest,
    input  logic [15:0] wb_data,
    output lc3b_ipacket ipacket_out,
    output logic [15:0] sr1_out,
    output logic [15:0] sr2_out,
    output logic [15:0] sext_out,
    output logic        stall_out
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } id_state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

    id_state_t    state_reg, state_next;
    logic [1:0]   cnt_reg, cnt_next;

    lc3b_opcode   opcode;
    lc3b_reg      sr1_idx, sr2_idx, dest_idx;
    lc3b_sext_sel sext_sel;
    logic         is_load, is_store, sr1_used, sr2_used, imm_mode, regfile_we;
    logic         exe_is_load, load_use, pkt_valid;

    id_regfile #(
        .RESET_VALUE (REG_RESET_VALUE)
    ) u_regfile (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_idx_a  (sr1_idx),
        .rd_idx_b  (sr2_idx),
        .rd_data_a (sr1_out),
        .rd_data_b (sr2_out),
        .we        (wb_en),
        .wr_idx    (wb_dest),
        .wr_data   (wb_data)
    );

    assign opcode   = lc3b_opcode'(instr_in[15:12]);
    assign is_load  = (opcode == OP_LDR) || (opcode == OP_LDB) || (opcode == OP_LDI);
    assign is_store = (opcode == OP_STR) || (opcode == OP_STB) || (opcode == OP_STI);
    assign imm_mode = ((opcode == OP_ADD) || (opcode == OP_AND)) && instr_in[5];

    // Stores read their data register through the sr2 port.
    assign sr1_idx  = instr_in[8:6];
    assign sr2_idx  = is_store ? instr_in[11:9] : instr_in[2:0];
    assign dest_idx = ((opcode == OP_JSR) || (opcode == OP_TRAP)) ? R7_IDX : instr_in[11:9];

    always_comb begin
        sr1_used   = 1'b0;
        regfile_we = 1'b0;
        sext_sel   = SEXT_NONE;
        case (opcode)
            OP_ADD, OP_AND: begin
                sr1_used   = 1'b1;
                regfile_we = 1'b1;
                sext_sel   = SEXT_IMM5;
            end
            OP_NOT: begin
                sr1_used   = 1'b1;
                regfile_we = 1'b1;
            end
            OP_SHF: begin
                sr1_used   = 1'b1;
                regfile_we = 1'b1;
                sext_sel   = ZEXT_IMM4;
            end
            OP_LDR, OP_LDB, OP_LDI: begin
                sr1_used   = 1'b1;
                regfile_we = 1'b1;
                sext_sel   = SEXT_OFF6;
            end
            OP_STR, OP_STB, OP_STI: begin
                sr1_used   = 1'b1;
                sext_sel   = SEXT_OFF6;
            end
            OP_JMP: sr1_used = 1'b1;
            OP_BR:  sext_sel = SEXT_OFF9;
            OP_LEA: begin
                regfile_we = 1'b1;
                sext_sel   = SEXT_OFF9;
            end
            // instr[11] selects JSR (PC-relative) over JSRR (base register).
            OP_JSR: begin
                regfile_we = 1'b1;
                sr1_used   = !instr_in[11];
                sext_sel   = instr_in[11] ? SEXT_OFF11 : SEXT_NONE;
            end
            OP_TRAP: begin
                regfile_we = 1'b1;
                sext_sel   = ZEXT_TRAP8;
            end
            default: ;
        endcase
    end

    assign sr2_used = (((opcode == OP_ADD) || (opcode == OP_AND)) && !instr_in[5]) || is_store;
    assign sext_out = extend_imm(sext_sel, instr_in);

    assign exe_is_load = (exe_ipacket.opcode == OP_LDR) || (exe_ipacket.opcode == OP_LDB)
                      || (exe_ipacket.opcode == OP_LDI);
    assign load_use = instr_valid && exe_ipacket.valid && exe_is_load
                   && ((sr1_used && (exe_ipacket.dest == sr1_idx))
                    || (sr2_used && (exe_ipacket.dest == sr2_idx)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_out  = 1'b0;
        pkt_valid  = 1'b0;
        if (!reset_n) begin
            state_next = ST_RUN;
            cnt_next   = 2'd0;
        end else if (flush) begin
            state_next = ST_RUN;
            cnt_next   = 2'd0;
        end else if (mem_stall) begin
            // ID/EXE is frozen, so the packet is informational only.
            stall_out = 1'b1;
            pkt_valid = (state_reg == ST_RUN) && instr_valid && !load_use;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (load_use) begin
                        stall_out  = 1'b1;
                        state_next = ST_HOLD;
                        cnt_next   = CNT_INIT;
                    end else begin
                        pkt_valid = instr_valid;
                    end
                end
                ST_HOLD: begin
                    stall_out = 1'b1;
                    if (cnt_reg == 2'd0)
                        state_next = ST_RUN;
                    else
                        cnt_next = cnt_reg - 2'd1;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        ipacket_out            = '0;
        ipacket_out.valid      = pkt_valid;
        ipacket_out.opcode     = opcode;
        ipacket_out.dest       = dest_idx;
        ipacket_out.sr1        = sr1_idx;
        ipacket_out.sr2        = sr2_idx;
        ipacket_out.pc         = pc_in;
        ipacket_out.imm_mode   = imm_mode;
        ipacket_out.load_en    = is_load;
        ipacket_out.store_en   = is_store;
        ipacket_out.regfile_we = regfile_we;
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: expectations are queued as each step is
// driven and compared against the DUT outputs before the next clock edge.
module tb_id_decode_stage;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr_in, pc_in, wb_data;
    logic        instr_valid, flush, mem_stall, wb_en;
    lc3b_ipacket exe_ipacket, ipacket_out;
    lc3b_reg     wb_dest;
    logic [15:0] sr1_out, sr2_out, sext_out;
    logic        stall_out;

    always #5 clk = ~clk;

    id_decode_stage #(
        .LOAD_USE_STALLS (2),
        .REG_RESET_VALUE (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .instr_valid (instr_valid),
        .flush       (flush),
        .mem_stall   (mem_stall),
        .exe_ipacket (exe_ipacket),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .ipacket_out (ipacket_out),
        .sr1_out     (sr1_out),
        .sr2_out     (sr2_out),
        .sext_out    (sext_out),
        .stall_out   (stall_out)
    );

    typedef enum int {SIG_SR1, SIG_SR2, SIG_SEXT, SIG_STALL, SIG_VALID, SIG_DEST} sig_t;
    typedef struct {
        string       tag;
        sig_t        sig;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [15:0] observe(input sig_t s);
        case (s)
            SIG_SR1:   return sr1_out;
            SIG_SR2:   return sr2_out;
            SIG_SEXT:  return sext_out;
            SIG_STALL: return {15'b0, stall_out};
            SIG_VALID: return {15'b0, ipacket_out.valid};
            SIG_DEST:  return {13'b0, ipacket_out.dest};
            default:   return 16'hxxxx;
        endcase
    endfunction

    function automatic lc3b_ipacket mk_exe(input logic v, input lc3b_opcode op, input lc3b_reg d);
        lc3b_ipacket p;
        p        = '0;
        p.valid  = v;
        p.opcode = op;
        p.dest   = d;
        return p;
    endfunction

    task automatic expect_sig(input string tag, input sig_t s, input logic [15:0] v);
        sb.push_back('{tag, s, v});
    endtask

    task automatic expect_flow(input string tag, input logic stall, input logic valid);
        expect_sig({tag, "_stall"}, SIG_STALL, {15'b0, stall});
        expect_sig({tag, "_valid"}, SIG_VALID, {15'b0, valid});
    endtask

    // Compare every queued expectation at the falling edge, then advance one clock.
    task automatic check_step(input string step);
        exp_t        e;
        logic [15:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
        $display("step %s stall=%0b valid=%0b sr1=%h sr2=%h sext=%h", step, stall_out,
                 ipacket_out.valid, sr1_out, sr2_out, sext_out);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        instr_in    = 16'h12C3;
        pc_in       = 16'h3000;
        instr_valid = 1'b1;
        flush       = 1'b0;
        mem_stall   = 1'b0;
        exe_ipacket = mk_exe(1'b0, OP_ADD, 3'd0);
        wb_en       = 1'b0;
        wb_dest     = 3'd0;
        wb_data     = 16'h0000;

        // Reset held for two clocks
        expect_flow("reset0", 1'b0, 1'b0);
        check_step("reset0");
        expect_flow("reset1", 1'b0, 1'b0);
        check_step("reset1");
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            instr_in = 16'h1000 | 16'(i << 6) | 16'(i);
            expect_sig($sformatf("reset_r%0d", i), SIG_SR1, 16'h0000);
            if (i == 0) expect_flow("post_reset", 1'b0, 1'b1);
            check_step($sformatf("read_r%0d", i));
        end

        // Write-through bypass: ADD R1,R3,R3 while R3 is written
        wb_en = 1'b1; wb_dest = 3'd3; wb_data = 16'hBEEF;
        instr_in = 16'h12C3;
        expect_sig("wt_sr1", SIG_SR1, 16'hBEEF);
        expect_sig("wt_sr2", SIG_SR2, 16'hBEEF);
        check_step("write_through");
        wb_dest = 3'd2; wb_data = 16'h1234;
        expect_sig("wt_other_sr1", SIG_SR1, 16'hBEEF);
        check_step("write_other");
        wb_dest = 3'd0; wb_data = 16'h00AA;
        instr_in = 16'h1080;
        expect_sig("r2_stored", SIG_SR1, 16'h1234);
        check_step("write_r0");
        wb_en = 1'b0;
        instr_in = 16'h1200;
        expect_sig("r0_ordinary", SIG_SR1, 16'h00AA);
        check_step("read_r0");

        // Immediate extension and destination override
        instr_in = 16'h127F;
        expect_sig("sext_imm5", SIG_SEXT, 16'hFFFF);
        check_step("imm5");
        instr_in = 16'h0FF0;
        expect_sig("sext_off9", SIG_SEXT, 16'hFFF0);
        check_step("off9");
        instr_in = 16'h6A9F;
        expect_sig("sext_off6", SIG_SEXT, 16'h001F);
        check_step("off6");
        instr_in = 16'hD2A5;
        expect_sig("zext_imm4", SIG_SEXT, 16'h0005);
        check_step("imm4");
        instr_in = 16'h4FFF;
        expect_sig("sext_off11", SIG_SEXT, 16'hFFFF);
        expect_sig("jsr_dest", SIG_DEST, 16'h0007);
        check_step("jsr");
        instr_in = 16'hF025;
        expect_sig("zext_trap", SIG_SEXT, 16'h0025);
        expect_sig("trap_dest", SIG_DEST, 16'h0007);
        check_step("trap");

        // Load-use: LDR R2 in EXE, ADD R4,R2,#1 in ID; detect + two HOLD cycles
        exe_ipacket = mk_exe(1'b1, OP_LDR, 3'd2);
        instr_in = 16'h18A1;
        expect_flow("lu_detect", 1'b1, 1'b0);
        check_step("lu_detect");
        exe_ipacket = mk_exe(1'b0, OP_ADD, 3'd0);
        expect_flow("lu_hold1", 1'b1, 1'b0);
        check_step("lu_hold1");
        expect_flow("lu_hold0", 1'b1, 1'b0);
        check_step("lu_hold0");
        expect_flow("lu_release", 1'b0, 1'b1);
        check_step("lu_release");

        // Cases that must not raise a hazard
        exe_ipacket = mk_exe(1'b1, OP_LDR, 3'd2);
        instr_in = 16'h1962;
        expect_flow("nohz_imm", 1'b0, 1'b1);
        check_step("nohz_imm");
        exe_ipacket = mk_exe(1'b1, OP_ADD, 3'd2);
        instr_in = 16'h18A1;
        expect_flow("nohz_alu", 1'b0, 1'b1);
        check_step("nohz_alu");
        exe_ipacket = mk_exe(1'b0, OP_LDR, 3'd2);
        expect_flow("nohz_bubble", 1'b0, 1'b1);
        check_step("nohz_bubble");
        exe_ipacket = mk_exe(1'b1, OP_LDR, 3'd2);
        instr_valid = 1'b0;
        expect_flow("nohz_invalid", 1'b0, 1'b0);
        check_step("nohz_invalid");
        instr_valid = 1'b1;

        // Store data register hazard, then flush while HOLD has cnt=1
        instr_in = 16'h7540;
        expect_flow("st_detect", 1'b1, 1'b0);
        check_step("st_detect");
        exe_ipacket = mk_exe(1'b0, OP_ADD, 3'd0);
        flush = 1'b1;
        expect_flow("flush_hold", 1'b0, 1'b0);
        check_step("flush_hold");
        flush = 1'b0;
        expect_flow("after_flush", 1'b0, 1'b1);
        check_step("after_flush");

        // mem_stall freezes the HOLD countdown
        exe_ipacket = mk_exe(1'b1, OP_LDB, 3'd2);
        instr_in = 16'h18A1;
        expect_flow("ms_detect", 1'b1, 1'b0);
        check_step("ms_detect");
        exe_ipacket = mk_exe(1'b0, OP_ADD, 3'd0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_sig($sformatf("ms_frozen%0d_stall", i), SIG_STALL, 16'h0001);
            check_step($sformatf("ms_frozen%0d", i));
        end
        mem_stall = 1'b0;
        expect_flow("ms_hold1", 1'b1, 1'b0);
        check_step("ms_hold1");
        expect_flow("ms_hold0", 1'b1, 1'b0);
        check_step("ms_hold0");
        expect_flow("ms_release", 1'b0, 1'b1);
        check_step("ms_release");

        // Reset while in HOLD returns to RUN
        exe_ipacket = mk_exe(1'b1, OP_LDI, 3'd2);
        expect_flow("rst_detect", 1'b1, 1'b0);
        check_step("rst_detect");
        exe_ipacket = mk_exe(1'b0, OP_ADD, 3'd0);
        reset_n = 1'b0;
        expect_flow("rst_in_hold", 1'b0, 1'b0);
        check_step("rst_in_hold");
        reset_n = 1'b1;
        expect_flow("rst_run", 1'b0, 1'b1);
        check_step("rst_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
